alu_sequence_arbiter: RTL and testbench

- Shares the 5-phase sequence counter (one-hot `phase[4:0]`, started by `begin_signal`, stopped by `end_signal`) between two requesters.
- Arbitrates round-robin and latches the winner's opcode.
- Drives the counter's begin/end controls for a programmed number of full phase rotations.
- Checks that phases stay legal, then acknowledges the winner.
- Sits between the ALU front-end requesters and the sequence counter/decoder.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/rr_arbiter_2.sv | 19 +
 rtl/alu_sequence_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_sequence_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequence arbiter: FSM encoding,
// the two phase codes the arbiter cares about, and the watchdog limit.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_STOP  = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    localparam logic [4:0] PHASE0 = 5'b00001;
    localparam logic [4:0] PHASE4 = 5'b10000;

    // One full rotation takes 5 cycles; one extra cycle of slack before the watchdog trips.
    function automatic int wd_limit(input int num_passes);
        return 5 * num_passes + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone request wins outright, on a tie the
// requester that was not served last wins.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = 2'b00;
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = last_grant_i ? 2'b01 : 2'b10;
            default: win_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_sequence_arbiter.sv
// Shares the 5-phase sequence counter between two ALU requesters: grants one,
// runs the counter for NUM_PASSES rotations, checks the phases and acknowledges.
module alu_sequence_arbiter
    import alu_seq_pkg::*;
#(
    parameter int OPW        = 3,
    parameter int NUM_PASSES = 1,
    parameter int PW         = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req,
    input  logic [OPW-1:0] op0,
    input  logic [OPW-1:0] op1,
    input  logic [4:0]     phase,
    output logic           begin_signal,
    output logic           end_signal,
    output logic [1:0]     grant,
    output logic [OPW-1:0] op_sel,
    output logic [1:0]     ack,
    output logic           busy,
    output logic           phase_err
);

    // PW+3 bits always covers 5*NUM_PASSES+2 when NUM_PASSES fits in PW bits.
    localparam int             WDW       = PW + 3;
    localparam logic [WDW-1:0] WD_LIMIT  = WDW'(wd_limit(NUM_PASSES));
    localparam logic [PW-1:0]  LAST_PASS = PW'(NUM_PASSES - 1);

    state_t         state_q;
    logic [1:0]     grant_q;
    logic [OPW-1:0] op_sel_q;
    logic [1:0]     ack_q;
    logic           busy_q;
    logic           begin_q;
    logic           err_q;
    logic           last_grant_q;
    logic [PW-1:0]  pass_q;
    logic [WDW-1:0] wd_q;

    logic [1:0]     win;
    logic [WDW-1:0] wd_d;
    logic           phase_onehot;
    logic           run_err;
    logic           run_done;

    rr_arbiter_2 u_arb (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .win_o        (win)
    );

    assign phase_onehot = (phase != 5'd0) && ((phase & (phase - 5'd1)) == 5'd0);
    assign wd_d         = wd_q + 1'b1;
    assign run_err      = (state_q == ST_RUN) && (!phase_onehot || (wd_d > WD_LIMIT));
    assign run_done     = (state_q == ST_RUN) && (phase == PHASE4) && (pass_q == LAST_PASS);

    // end_signal must clear the counter's run flag in the same cycle the last phase is seen.
    assign end_signal   = run_err | run_done;
    assign phase_err    = err_q | run_err;
    assign begin_signal = begin_q;
    assign grant        = grant_q;
    assign op_sel       = op_sel_q;
    assign ack          = ack_q;
    assign busy         = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            op_sel_q     <= '0;
            ack_q        <= 2'b00;
            busy_q       <= 1'b0;
            begin_q      <= 1'b0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
            pass_q       <= '0;
            wd_q         <= '0;
        end else begin
            begin_q <= 1'b0;
            ack_q   <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q  <= win;
                        op_sel_q <= win[0] ? op0 : op1;
                        begin_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_START;
                    end
                end
                ST_START: begin
                    pass_q  <= '0;
                    wd_q    <= '0;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    wd_q <= wd_d;
                    if (run_err) begin
                        err_q   <= 1'b1;
                        state_q <= ST_STOP;
                    end else if (phase == PHASE4) begin
                        if (pass_q == LAST_PASS) begin
                            state_q <= ST_STOP;
                        end else begin
                            pass_q <= pass_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (phase != PHASE0) begin
                        err_q <= 1'b1;
                    end
                    ack_q   <= grant_q;
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    grant_q      <= 2'b00;
                    last_grant_q <= grant_q[1];
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequence_arbiter.sv
// Directed bench: two arbiter instances (1 and 3 passes) each driving a model
// of the sequence counter; acks of instance A are checked against a scoreboard.
module tb_alu_sequence_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: NUM_PASSES = 1, with phase override for fault injection
    logic [1:0] req_a;
    logic [2:0] op0_a, op1_a, op_sel_a;
    logic [4:0] phase_a, cnt_a, ovr_val;
    logic       ovr_en, reload, run_a;
    logic       begin_a, end_a, busy_a, err_a;
    logic [1:0] grant_a, ack_a;

    // instance B: NUM_PASSES = 3
    logic [1:0] req_b;
    logic [2:0] op0_b, op1_b, op_sel_b;
    logic [4:0] phase_b, cnt_b;
    logic       run_b, begin_b, end_b, busy_b, err_b;
    logic [1:0] grant_b, ack_b;

    assign phase_a = ovr_en ? ovr_val : cnt_a;
    assign phase_b = cnt_b;

    alu_sequence_arbiter #(.OPW(3), .NUM_PASSES(1), .PW(4)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .op0(op0_a), .op1(op1_a),
        .phase(phase_a), .begin_signal(begin_a), .end_signal(end_a),
        .grant(grant_a), .op_sel(op_sel_a), .ack(ack_a), .busy(busy_a),
        .phase_err(err_a)
    );

    alu_sequence_arbiter #(.OPW(3), .NUM_PASSES(3), .PW(4)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .op0(op0_b), .op1(op1_b),
        .phase(phase_b), .begin_signal(begin_b), .end_signal(end_b),
        .grant(grant_b), .op_sel(op_sel_b), .ack(ack_b), .busy(busy_b),
        .phase_err(err_b)
    );

    // Sequence counter model: run flag set by begin, cleared by end; phase rotates while running.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_a <= 5'b00001;
            run_a <= 1'b0;
        end else if (reload) begin
            cnt_a <= 5'b00001;
            run_a <= 1'b0;
        end else begin
            if (run_a) cnt_a <= {cnt_a[3:0], cnt_a[4]};
            if (end_a) run_a <= 1'b0;
            else if (begin_a) run_a <= 1'b1;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_b <= 5'b00001;
            run_b <= 1'b0;
        end else begin
            if (run_b) cnt_b <= {cnt_b[3:0], cnt_b[4]};
            if (end_b) run_b <= 1'b0;
            else if (begin_b) run_b <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [1:0] ack;
        logic [2:0] op;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    task automatic push(input logic [1:0] a, input logic [2:0] o, input int c);
        exp_t e;
        e.ack = a;
        e.op  = o;
        e.cyc = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && ack_a != 2'b00) begin
            $display("ack=%b op_sel=%0h cycle=%0d", ack_a, op_sel_a, cyc);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, ack_a}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_ack", {30'd0, ack_a}, {30'd0, e.ack});
                chk("sb_op", {29'd0, op_sel_a}, {29'd0, e.op});
                chk("sb_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int m;
        req_a = 2'b00; op0_a = 3'd0; op1_a = 3'd0;
        ovr_en = 1'b0; ovr_val = 5'd0; reload = 1'b0;
        req_b = 2'b00; op0_b = 3'd0; op1_b = 3'd0;

        step(2);
        chk("rst_grant", {30'd0, grant_a}, 0);
        chk("rst_busy", {31'd0, busy_a}, 0);
        chk("rst_ack", {30'd0, ack_a}, 0);
        chk("rst_begin", {31'd0, begin_a}, 0);
        chk("rst_end", {31'd0, end_a}, 0);
        chk("rst_err", {31'd0, err_a}, 0);
        chk("rst_op", {29'd0, op_sel_a}, 0);
        reset = 1'b0;
        step(1);

        // single request from requester 0
        n = cyc;
        req_a = 2'b01; op0_a = 3'b101; op1_a = 3'b010;
        push(2'b01, 3'b101, n + 8);
        step(1);
        chk("t1_grant", {30'd0, grant_a}, 32'h1);
        chk("t1_op", {29'd0, op_sel_a}, 32'h5);
        chk("t1_begin", {31'd0, begin_a}, 1);
        chk("t1_busy", {31'd0, busy_a}, 1);
        op0_a = 3'b010;
        step(1);
        chk("t1_begin_once", {31'd0, begin_a}, 0);
        chk("t1_op_hold", {29'd0, op_sel_a}, 32'h5);
        step(3);
        chk("t1_end_early", {31'd0, end_a}, 0);
        step(1);
        chk("t1_end", {31'd0, end_a}, 1);
        chk("t1_phase4", {27'd0, phase_a}, 32'h10);
        step(1);
        chk("t1_end_once", {31'd0, end_a}, 0);
        chk("t1_stop_phase", {27'd0, phase_a}, 32'h01);
        chk("t1_no_early_ack", {30'd0, ack_a}, 0);
        step(1);
        chk("t1_ack", {30'd0, ack_a}, 32'h1);
        chk("t1_err", {31'd0, err_a}, 0);
        req_a = 2'b00;
        step(1);
        chk("t1_idle_busy", {31'd0, busy_a}, 0);
        chk("t1_idle_grant", {30'd0, grant_a}, 0);

        // both requesters held: strict alternation starting with requester 0
        do_reset();
        n = cyc;
        req_a = 2'b11; op0_a = 3'b011; op1_a = 3'b110;
        push(2'b01, 3'b011, n + 8);
        push(2'b10, 3'b110, n + 17);
        push(2'b01, 3'b011, n + 26);
        push(2'b10, 3'b110, n + 35);
        step(1);
        chk("t2_first_grant", {30'd0, grant_a}, 32'h1);
        step(34);
        req_a = 2'b00;
        step(2);
        chk("t2_idle", {31'd0, busy_a}, 0);
        chk("t2_drained", sb.size(), 0);

        // illegal multi-bit phase during RUN
        do_reset();
        n = cyc;
        req_a = 2'b01; op0_a = 3'b001;
        push(2'b01, 3'b001, n + 5);
        step(3);
        ovr_val = 5'b00110; ovr_en = 1'b1;
        #1;
        chk("t3_end", {31'd0, end_a}, 1);
        chk("t3_err", {31'd0, err_a}, 1);
        step(1);
        ovr_en = 1'b0;
        chk("t3_err_hold", {31'd0, err_a}, 1);
        step(1);
        chk("t3_ack", {30'd0, ack_a}, 32'h1);
        req_a = 2'b00; reload = 1'b1;
        step(1);
        reload = 1'b0;
        n = cyc;
        req_a = 2'b10; op1_a = 3'b100;
        push(2'b10, 3'b100, n + 8);
        step(6);
        chk("t3_clean_end", {31'd0, end_a}, 1);
        step(2);
        req_a = 2'b00;
        chk("t3_sticky", {31'd0, err_a}, 1);
        step(1);
        do_reset();
        chk("t3_err_cleared", {31'd0, err_a}, 0);

        // stalled counter: watchdog trip
        n = cyc;
        req_a = 2'b01; op0_a = 3'b111;
        push(2'b01, 3'b111, n + 10);
        step(1);
        ovr_val = 5'b00100; ovr_en = 1'b1;
        step(6);
        chk("t4_no_trip", {31'd0, end_a}, 0);
        chk("t4_no_err", {31'd0, err_a}, 0);
        step(1);
        chk("t4_trip_end", {31'd0, end_a}, 1);
        chk("t4_trip_err", {31'd0, err_a}, 1);
        step(1);
        ovr_en = 1'b0;
        step(1);
        chk("t4_ack", {30'd0, ack_a}, 32'h1);
        req_a = 2'b00; reload = 1'b1;
        step(1);
        reload = 1'b0;

        // three passes per operation on instance B
        n = cyc;
        req_b = 2'b10; op0_b = 3'b001; op1_b = 3'b111;
        step(1);
        chk("t5_grant", {30'd0, grant_b}, 32'h2);
        chk("t5_op", {29'd0, op_sel_b}, 32'h7);
        step(5);
        chk("t5_pass1_phase", {27'd0, phase_b}, 32'h10);
        chk("t5_pass1_end", {31'd0, end_b}, 0);
        step(5);
        chk("t5_pass2_phase", {27'd0, phase_b}, 32'h10);
        chk("t5_pass2_end", {31'd0, end_b}, 0);
        step(5);
        chk("t5_pass3_end", {31'd0, end_b}, 1);
        step(1);
        chk("t5_stop_phase", {27'd0, phase_b}, 32'h01);
        chk("t5_no_early_ack", {30'd0, ack_b}, 0);
        step(1);
        chk("t5_ack", {30'd0, ack_b}, 32'h2);
        chk("t5_err", {31'd0, err_b}, 0);
        chk("t5_ack_cycle", cyc, n + 18);
        req_b = 2'b00;
        step(1);

        // asynchronous reset in the middle of RUN
        do_reset();
        n = cyc;
        req_a = 2'b11; op0_a = 3'b010; op1_a = 3'b011;
        step(4);
        reset = 1'b1;
        #1;
        chk("t6_grant", {30'd0, grant_a}, 0);
        chk("t6_busy", {31'd0, busy_a}, 0);
        chk("t6_ack", {30'd0, ack_a}, 0);
        chk("t6_end", {31'd0, end_a}, 0);
        step(1);
        reset = 1'b0;
        m = cyc;
        push(2'b01, 3'b010, m + 8);
        step(1);
        chk("t6_regrant", {30'd0, grant_a}, 32'h1);
        step(7);
        req_a = 2'b00;
        step(2);
        chk("t6_err", {31'd0, err_a}, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
